// File: rtl/condicionador_botoes_if.sv
// Bundle between the raw switch inputs and the conditioned outputs of
// condicionador_botoes. The stimulus side uses master; the conditioner uses slave.
interface condicionador_botoes_if #(
  parameter int N_CANAIS = 5
);
  logic [N_CANAIS-1:0]   entrada;
  logic [N_CANAIS-1:0]   nivel;
  logic [N_CANAIS-1:0]   pulso;
  logic                  qualquer;
  logic                  multiplo;
  logic [2*N_CANAIS-1:0] db_estado;

  modport master (
    output entrada,
    input  nivel, pulso, qualquer, multiplo, db_estado
  );

  modport slave (
    input  entrada,
    output nivel, pulso, qualquer, multiplo, db_estado
  );
endinterface

// File: rtl/condicionador_botoes.sv
// Input conditioner for the game buttons (bits 3:0) and jogar (bit 4).
// Each channel has a 2-FF synchroniser and an independent debounce FSM.
// A channel's level changes only after the synchronised input has differed
// from it for DEBOUNCE_CICLOS consecutive cycles. A one-cycle pulse marks
// each accepted press. The any/multiple flags are registered from the
// next-state level, so they move in the same cycle as nivel.
module condicionador_botoes #(
  parameter int N_CANAIS        = 5,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  condicionador_botoes_if.slave bus
);

  localparam int             CW      = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    EST0   = 2'b00,
    CONTA1 = 2'b01,
    CONTA0 = 2'b10,
    EST1   = 2'b11
  } estado_t;

  logic [N_CANAIS-1:0]   sync1_q, sync1_d;
  logic [N_CANAIS-1:0]   sync2_q, sync2_d;
  logic [N_CANAIS-1:0]   nivel_q, nivel_d;
  logic [N_CANAIS-1:0]   pulso_q, pulso_d;
  logic                  qualquer_q, qualquer_d;
  logic                  multiplo_q, multiplo_d;
  logic [2*N_CANAIS-1:0] db_estado_w;

  // Synchroniser chain: entrada reaches sync2 two clocks later
  always_comb begin
    sync1_d = bus.entrada;
    sync2_d = sync1_q;
  end

  // Flags come from the next-state level so they align with nivel
  always_comb begin
    qualquer_d = |nivel_d;
    multiplo_d = (nivel_d & (nivel_d - N_CANAIS'(1))) != '0;
  end

  // Shared output and synchroniser registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      nivel_q    <= '0;
      pulso_q    <= '0;
      qualquer_q <= 1'b0;
      multiplo_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      nivel_q    <= nivel_d;
      pulso_q    <= pulso_d;
      qualquer_q <= qualquer_d;
      multiplo_q <= multiplo_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CANAIS; gi++) begin : g_canal
      estado_t       estado_q, estado_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          nivel_ch_d;
      logic          pulso_ch_d;
      logic          s;

      assign s = sync2_q[gi];

      // Per-channel debounce state and counter
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          estado_q <= EST0;
          cnt_q    <= '0;
        end else begin
          estado_q <= estado_d;
          cnt_q    <= cnt_d;
        end
      end

      // Debounce FSM: any disagreement in a counting state restarts from zero
      always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        nivel_ch_d = nivel_q[gi];
        pulso_ch_d = 1'b0;
        case (estado_q)
          EST0: begin
            if (s) begin
              if (DEBOUNCE_CICLOS == 1) begin
                nivel_ch_d = 1'b1;
                pulso_ch_d = 1'b1;
                estado_d   = EST1;
              end else begin
                cnt_d    = CNT_ONE;
                estado_d = CONTA1;
              end
            end
          end
          CONTA1: begin
            if (!s) begin
              cnt_d    = '0;
              estado_d = EST0;
            end else if (cnt_q == CNT_MAX) begin
              nivel_ch_d = 1'b1;
              pulso_ch_d = 1'b1;
              cnt_d      = '0;
              estado_d   = EST1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          EST1: begin
            if (!s) begin
              if (DEBOUNCE_CICLOS == 1) begin
                nivel_ch_d = 1'b0;
                estado_d   = EST0;
              end else begin
                cnt_d    = CNT_ONE;
                estado_d = CONTA0;
              end
            end
          end
          CONTA0: begin
            if (s) begin
              cnt_d    = '0;
              estado_d = EST1;
            end else if (cnt_q == CNT_MAX) begin
              nivel_ch_d = 1'b0;
              cnt_d      = '0;
              estado_d   = EST0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            cnt_d    = '0;
            estado_d = EST0;
          end
        endcase
      end

      assign nivel_d[gi]            = nivel_ch_d;
      assign pulso_d[gi]            = pulso_ch_d;
      assign db_estado_w[2*gi +: 2] = estado_q;
    end
  endgenerate

  assign bus.nivel     = nivel_q;
  assign bus.pulso     = pulso_q;
  assign bus.qualquer  = qualquer_q;
  assign bus.multiplo  = multiplo_q;
  assign bus.db_estado = db_estado_w;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: two instances (debounce 4 and 1) share the
// same stimulus. A run-length reference model produces the expected outputs
// when each input is driven; they are queued and compared after the edge.
module tb_condicionador_botoes;

  logic clk;
  logic rst_n;

  condicionador_botoes_if #(.N_CANAIS(5)) if4 ();
  condicionador_botoes_if #(.N_CANAIS(5)) if1 ();

  condicionador_botoes #(.N_CANAIS(5), .DEBOUNCE_CICLOS(4)) dut4 (
    .clock (clk),
    .reset (rst_n),
    .bus   (if4)
  );

  condicionador_botoes #(.N_CANAIS(5), .DEBOUNCE_CICLOS(1)) dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       s1;
    logic [4:0]       s2;
    logic [4:0]       lvl;
    logic [4:0]       pul;
    logic [4:0][15:0] run;
  } model_t;

  typedef struct packed {
    logic [4:0] nivel;
    logic [4:0] pulso;
    logic       qualquer;
    logic       multiplo;
    logic [9:0] estado;
  } obs_t;

  model_t m4, m1;
  obs_t   q4[$];
  obs_t   q1[$];
  obs_t   obs4, obs1;
  int     n_chk;
  int     n_err;

  assign obs4 = {if4.nivel, if4.pulso, if4.qualquer, if4.multiplo, if4.db_estado};
  assign obs1 = {if1.nivel, if1.pulso, if1.qualquer, if1.multiplo, if1.db_estado};

  // Level flips once the synchronised input has disagreed for d cycles in a row
  function automatic model_t model_step(model_t m, logic [4:0] e, int d);
    model_t     n = m;
    logic [4:0] s = m.s2;
    n.s2  = m.s1;
    n.s1  = e;
    n.pul = '0;
    for (int i = 0; i < 5; i++) begin
      if (s[i] != m.lvl[i]) begin
        n.run[i] = m.run[i] + 16'd1;
        if (int'(n.run[i]) == d) begin
          n.lvl[i] = s[i];
          n.run[i] = '0;
          n.pul[i] = s[i];
        end
      end else begin
        n.run[i] = '0;
      end
    end
    return n;
  endfunction

  function automatic obs_t expect_of(model_t m);
    obs_t o;
    int   ones = 0;
    o.nivel  = m.lvl;
    o.pulso  = m.pul;
    o.estado = '0;
    for (int i = 0; i < 5; i++) begin
      if (m.lvl[i]) ones++;
      if (m.run[i] != '0) o.estado[2*i +: 2] = m.lvl[i] ? 2'b10 : 2'b01;
      else                o.estado[2*i +: 2] = m.lvl[i] ? 2'b11 : 2'b00;
    end
    o.qualquer = (ones >= 1);
    o.multiplo = (ones >= 2);
    return o;
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // One transaction: drive, predict, clock, compare
  task automatic tick(logic [4:0] e);
    obs_t x4, x1;
    if4.entrada = e;
    if1.entrada = e;
    if (rst_n) begin
      m4 = model_step(m4, e, 4);
      m1 = model_step(m1, e, 1);
    end
    q4.push_back(expect_of(m4));
    q1.push_back(expect_of(m1));
    @(posedge clk);
    @(negedge clk);
    x4 = q4.pop_front();
    x1 = q1.pop_front();
    check_val("deb4_outputs", {10'b0, obs4}, {10'b0, x4});
    check_val("deb1_outputs", {10'b0, obs1}, {10'b0, x1});
    $display("t=%0t rst_n=%b entrada=%b | d4 nivel=%b pulso=%b q=%b m=%b est=%b | d1 nivel=%b pulso=%b",
             $time, rst_n, e, if4.nivel, if4.pulso, if4.qualquer, if4.multiplo,
             if4.db_estado, if1.nivel, if1.pulso);
  endtask

  task automatic ticks(logic [4:0] e, int n);
    for (int k = 0; k < n; k++) tick(e);
  endtask

  // Assert reset between clock edges; outputs must clear without a clock
  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    check_val({tag, "_d4"}, {10'b0, obs4}, 32'd0);
    check_val({tag, "_d1"}, {10'b0, obs1}, 32'd0);
    m4 = '0;
    m1 = '0;
  endtask

  initial begin
    logic [4:0] r;
    n_chk = 0;
    n_err = 0;
    m4 = '0;
    m1 = '0;
    rst_n = 1'b0;
    if4.entrada = 5'b11111;
    if1.entrada = 5'b11111;

    // Reset with all inputs high: everything held at zero
    #1;
    check_val("reset_state_d4", {10'b0, obs4}, 32'd0);
    check_val("reset_state_d1", {10'b0, obs1}, 32'd0);
    ticks(5'b11111, 2);
    rst_n = 1'b1;
    ticks(5'b11111, 8);
    ticks(5'b00000, 8);

    // Clean press and release on channel 0
    ticks(5'b00001, 8);
    ticks(5'b00000, 8);

    // Bounce on channel 2, then a lone 3-cycle glitch
    ticks(5'b00100, 3);
    tick(5'b00000);
    ticks(5'b00100, 8);
    ticks(5'b00000, 8);
    ticks(5'b00100, 3);
    ticks(5'b00000, 8);

    // Simultaneous press of channels 1 and 2, then release channel 1 only
    ticks(5'b00110, 8);
    ticks(5'b00100, 8);
    ticks(5'b00000, 8);

    // Reset while channel 3 is counting, and again while it is accepted
    ticks(5'b01000, 4);
    check_val("conta1_state_d4", {30'b0, if4.db_estado[7:6]}, 32'd1);
    async_reset("rst_conta1");
    ticks(5'b01000, 2);
    rst_n = 1'b1;
    ticks(5'b01000, 8);
    check_val("est1_nivel3_d4", {31'b0, if4.nivel[3]}, 32'd1);
    async_reset("rst_est1");
    ticks(5'b01000, 2);
    rst_n = 1'b1;
    ticks(5'b00000, 8);

    // Sustained hold on channel 1
    ticks(5'b00010, 40);
    ticks(5'b00000, 8);

    // Random slowly-toggling inputs
    r = 5'b00000;
    for (int k = 0; k < 60; k++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      tick(r);
    end
    ticks(5'b00000, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
